// File: rtl/hs_arb_pkg.sv
// Shared state encodings and arithmetic helpers for the hs arbiter family.
package hs_arb_pkg;

  typedef enum logic [1:0] {
    S_CREDIT = 2'd0,
    S_CHECK  = 2'd1,
    S_XFER   = 2'd2
  } arb_state_e;

  localparam int SAT_WD = 32;

  // Signed add clamped to [-lim, +lim]; operands are far narrower than SAT_WD, so the raw sum cannot wrap.
  function automatic logic signed [SAT_WD-1:0] sat_add(
    input logic signed [SAT_WD-1:0] a,
    input logic signed [SAT_WD-1:0] b,
    input logic signed [SAT_WD-1:0] lim
  );
    logic signed [SAT_WD-1:0] sum;
    sum = a + b;
    if (sum > lim) begin
      return lim;
    end else if (sum < -lim) begin
      return -lim;
    end else begin
      return sum;
    end
  endfunction

endpackage

// File: rtl/hs_deficit_counter.sv
// Per-port signed deficit register: credited by a quantum, debited one per beat,
// and stripped of unused positive credit when its port is found empty.
module hs_deficit_counter #(
  parameter int QUANTUM_WD = 8,
  parameter int DEFICIT_WD = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  add_quantum,
  input  logic                  dec_one,
  input  logic                  clr_pos,
  input  logic [QUANTUM_WD-1:0] quantum,
  output logic                  positive
);
  import hs_arb_pkg::*;

  localparam logic signed [SAT_WD-1:0] DEF_MAX = (32'sd1 <<< (DEFICIT_WD - 1)) - 32'sd1;

  logic signed [DEFICIT_WD-1:0] deficit_q, deficit_d;
  logic signed [SAT_WD-1:0]     delta_s;
  logic signed [SAT_WD-1:0]     sum_s;

  // Next deficit; the scheduler never raises more than one control at a time.
  always_comb begin
    delta_s = '0;
    if (add_quantum) begin
      delta_s = SAT_WD'(quantum);
    end else if (dec_one) begin
      delta_s = -32'sd1;
    end else begin
      delta_s = '0;
    end
    sum_s = sat_add(SAT_WD'(deficit_q), delta_s, DEF_MAX);
    if (clr_pos && positive) begin
      deficit_d = '0;
    end else begin
      deficit_d = sum_s[DEFICIT_WD-1:0];
    end
  end

  // Deficit state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deficit_q <= '0;
    end else begin
      deficit_q <= deficit_d;
    end
  end

  assign positive = !deficit_q[DEFICIT_WD-1] && (deficit_q != '0);

endmodule

// File: rtl/hs_drr_scheduler.sv
// Deficit-round-robin packet scheduler merging REQ_NUM valid/ready/last streams
// into one, locking the output to a single port for the whole packet.
module hs_drr_scheduler #(
  parameter int REQ_NUM    = 4,
  parameter int QUANTUM_WD = 8,
  parameter int DEFICIT_WD = 12
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [REQ_NUM*QUANTUM_WD-1:0] quantum,
  input  logic [REQ_NUM-1:0]            valid_in,
  input  logic [REQ_NUM-1:0]            data_in,
  input  logic [REQ_NUM-1:0]            last_in,
  output logic [REQ_NUM-1:0]            ready_in,
  output logic                          valid_out,
  output logic                          data_out,
  output logic                          last_out,
  input  logic                          ready_out,
  output logic [$clog2(REQ_NUM)-1:0]    grant_idx,
  output logic                          busy
);
  import hs_arb_pkg::*;

  localparam int               IDX_W    = $clog2(REQ_NUM);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(REQ_NUM - 1);

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d, ptr_inc_s;
  logic [REQ_NUM-1:0] sel_oh_s, add_s, dec_s, clr_s, pos_s;
  logic               sel_valid_s, sel_data_s, sel_last_s, sel_pos_s;

  for (genvar gi = 0; gi < REQ_NUM; gi++) begin : g_port
    hs_deficit_counter #(
      .QUANTUM_WD (QUANTUM_WD),
      .DEFICIT_WD (DEFICIT_WD)
    ) u_deficit (
      .clk         (clk),
      .rst_n       (rst_n),
      .add_quantum (add_s[gi]),
      .dec_one     (dec_s[gi]),
      .clr_pos     (clr_s[gi]),
      .quantum     (quantum[gi*QUANTUM_WD +: QUANTUM_WD]),
      .positive    (pos_s[gi])
    );
  end

  // All per-port selection goes through the one-hot of ptr, which also drives ready_in directly.
  assign sel_oh_s    = REQ_NUM'(1) << ptr_q;
  assign sel_valid_s = |(valid_in & sel_oh_s);
  assign sel_data_s  = |(data_in  & sel_oh_s);
  assign sel_last_s  = |(last_in  & sel_oh_s);
  assign sel_pos_s   = |(pos_s    & sel_oh_s);
  assign ptr_inc_s   = (ptr_q == LAST_IDX) ? '0 : ptr_q + IDX_W'(1);

  // Scan/lock next-state logic and the merged output stream.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    add_s     = '0;
    dec_s     = '0;
    clr_s     = '0;
    valid_out = 1'b0;
    data_out  = 1'b0;
    last_out  = 1'b0;
    ready_in  = '0;
    case (state_q)
      S_CREDIT: begin
        if (sel_valid_s) begin
          add_s   = sel_oh_s;
          state_d = S_CHECK;
        end else begin
          clr_s = sel_oh_s;
          ptr_d = ptr_inc_s;
        end
      end
      S_CHECK: begin
        if (sel_valid_s && sel_pos_s) begin
          state_d = S_XFER;
        end else begin
          ptr_d   = ptr_inc_s;
          state_d = S_CREDIT;
        end
      end
      S_XFER: begin
        valid_out = sel_valid_s;
        data_out  = sel_data_s;
        last_out  = sel_last_s;
        ready_in  = sel_oh_s & {REQ_NUM{ready_out}};
        dec_s     = sel_oh_s & {REQ_NUM{sel_valid_s & ready_out}};
        if (sel_valid_s && ready_out && sel_last_s) begin
          state_d = S_CHECK;
        end else begin
          state_d = S_XFER;
        end
      end
      default: begin
        state_d = S_CREDIT;
        ptr_d   = '0;
      end
    endcase
  end

  // State and scan-pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_CREDIT;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  assign busy      = (state_q == S_XFER);
  assign grant_idx = ptr_q;

endmodule

// File: tb/tb_hs_drr_scheduler.sv
// Randomised bench for hs_drr_scheduler against a packet-level deficit-round-robin model.
module tb_hs_drr_scheduler;
  localparam int REQ_NUM    = 4;
  localparam int QUANTUM_WD = 8;
  localparam int DEFICIT_WD = 12;
  localparam int IDX_W      = 2;

  typedef struct packed {
    logic [7:0] port;
    logic       data;
    logic       last;
  } beat_t;

  logic                          clk = 1'b0;
  logic                          rst_n = 1'b0;
  logic [REQ_NUM*QUANTUM_WD-1:0] quantum = '0;
  logic [REQ_NUM-1:0]            valid_in = '0;
  logic [REQ_NUM-1:0]            data_in = '0;
  logic [REQ_NUM-1:0]            last_in = '0;
  logic [REQ_NUM-1:0]            ready_in;
  logic                          valid_out, data_out, last_out, busy;
  logic                          ready_out = 1'b0;
  logic [IDX_W-1:0]              grant_idx;

  int    n_checks = 0;
  int    n_fail   = 0;
  beat_t drv_q[REQ_NUM][$];
  int    pkt_len[REQ_NUM][$];
  int    qv[REQ_NUM];
  logic  bubble[REQ_NUM];
  beat_t exp_q[$];
  int    start_cyc[$];
  int    beats_sent[REQ_NUM];

  hs_drr_scheduler #(
    .REQ_NUM    (REQ_NUM),
    .QUANTUM_WD (QUANTUM_WD),
    .DEFICIT_WD (DEFICIT_WD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .quantum   (quantum),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .last_in   (last_in),
    .ready_in  (ready_in),
    .valid_out (valid_out),
    .data_out  (data_out),
    .last_out  (last_out),
    .ready_out (ready_out),
    .grant_idx (grant_idx),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_traffic();
    for (int i = 0; i < REQ_NUM; i++) begin
      drv_q[i].delete();
      pkt_len[i].delete();
      bubble[i] = 1'b0;
    end
  endtask

  task automatic add_pkt(input int p, input int len);
    beat_t bt;
    for (int b = 0; b < len; b++) begin
      bt.port = 8'(p);
      bt.data = 1'($urandom);
      bt.last = (b == len - 1);
      drv_q[p].push_back(bt);
    end
    pkt_len[p].push_back(len);
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < REQ_NUM; i++) begin
      valid_in[i] = (drv_q[i].size() > 0) && !bubble[i];
      data_in[i]  = (drv_q[i].size() > 0) ? drv_q[i][0].data : 1'b0;
      last_in[i]  = (drv_q[i].size() > 0) ? drv_q[i][0].last : 1'b0;
      quantum[i*QUANTUM_WD +: QUANTUM_WD] = QUANTUM_WD'(qv[i]);
    end
  endtask

  // Packet-level DRR: visit ports in order, credit a waiting port, send whole packets while credit is positive.
  function automatic void build_expected();
    int d[REQ_NUM];
    int pi[REQ_NUM];
    int off[REQ_NUM];
    int ptr = 0;
    bit more = 1'b1;
    exp_q.delete();
    for (int i = 0; i < REQ_NUM; i++) begin
      d[i] = 0; pi[i] = 0; off[i] = 0;
    end
    while (more) begin
      if (pi[ptr] < pkt_len[ptr].size()) begin
        d[ptr] += qv[ptr];
        while (pi[ptr] < pkt_len[ptr].size() && d[ptr] > 0) begin
          for (int b = 0; b < pkt_len[ptr][pi[ptr]]; b++) exp_q.push_back(drv_q[ptr][off[ptr] + b]);
          off[ptr] += pkt_len[ptr][pi[ptr]];
          d[ptr]   -= pkt_len[ptr][pi[ptr]];
          pi[ptr]++;
        end
      end else if (d[ptr] > 0) begin
        d[ptr] = 0;
      end
      ptr  = (ptr + 1) % REQ_NUM;
      more = 1'b0;
      for (int i = 0; i < REQ_NUM; i++)
        if (pi[i] < pkt_len[i].size() && (qv[i] > 0 || d[i] > 0)) more = 1'b1;
    end
  endfunction

  task automatic apply_reset();
    rst_n     = 1'b0;
    ready_out = 1'b0;
    for (int i = 0; i < REQ_NUM; i++) bubble[i] = 1'b0;
    drive_inputs();
    repeat (2) begin
      @(negedge clk);
      check_eq("rst_valid_out", 32'(valid_out), 32'd0);
      check_eq("rst_last_out", 32'(last_out), 32'd0);
      check_eq("rst_ready_in", 32'(ready_in), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_grant_idx", 32'(grant_idx), 32'd0);
    end
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    ready_out = 1'b1;
  endtask

  // Sample cycle k (k=0 is the first cycle after reset release) on the falling edge, drive just after the rising edge.
  task automatic run_traffic(input int max_cyc, input int stall_pct, input int bubble_pct,
                             input int stall_beat, input int abort_at);
    int    cyc = 0;
    int    nbeats = 0;
    int    stall_left = 0;
    bit    stall_used = 1'b0, stall_now = 1'b0, prev_last_fire = 1'b0, at_start = 1'b1, fire;
    logic [REQ_NUM-1:0] took, took_last;
    beat_t e;
    start_cyc.delete();
    for (int i = 0; i < REQ_NUM; i++) beats_sent[i] = 0;
    build_expected();
    while (exp_q.size() > 0 && cyc < max_cyc) begin
      @(negedge clk);
      if (cyc == 0) check_eq("scan_start", 32'(grant_idx), 32'd0);
      check_eq("ready_onehot0", 32'($onehot0(ready_in)), 32'd1);
      if (prev_last_fire) check_eq("gap_after_last", 32'(valid_out), 32'd0);
      if (stall_now) check_eq("stall_valid", 32'(valid_out), 32'd1);
      if (valid_out) begin
        check_eq("busy", 32'(busy), 32'd1);
        check_eq("grant_idx", 32'(grant_idx), 32'(exp_q[0].port));
        check_eq("data_out", 32'(data_out), 32'(exp_q[0].data));
        check_eq("last_out", 32'(last_out), 32'(exp_q[0].last));
        check_eq("ready_in", 32'(ready_in), ready_out ? (32'd1 << exp_q[0].port) : 32'd0);
      end
      fire      = valid_out & ready_out;
      took      = valid_in & ready_in;
      took_last = took & last_in;
      if (fire) begin
        if (at_start) start_cyc.push_back(cyc);
        at_start = last_out;
        e = exp_q.pop_front();
        beats_sent[e.port]++;
        nbeats++;
      end
      prev_last_fire = fire & last_out;
      @(posedge clk);
      #1;
      for (int i = 0; i < REQ_NUM; i++) begin
        if (took[i]) begin
          void'(drv_q[i].pop_front());
          bubble[i] = !took_last[i] && (drv_q[i].size() > 0) && (int'($urandom_range(99)) < bubble_pct);
        end else if (bubble[i]) begin
          bubble[i] = (int'($urandom_range(99)) < bubble_pct);
        end
      end
      stall_now = 1'b0;
      if (stall_beat >= 0 && !stall_used && nbeats == stall_beat) begin
        stall_left = 5;
        stall_used = 1'b1;
      end
      if (stall_left > 0) begin
        ready_out = 1'b0;
        stall_left--;
        stall_now = 1'b1;
      end else begin
        ready_out = (int'($urandom_range(99)) >= stall_pct);
      end
      drive_inputs();
      cyc++;
      if (abort_at >= 0 && nbeats == abort_at) return;
    end
    check_eq("all_beats_sent", 32'(exp_q.size()), 32'd0);
    repeat (10) begin
      @(negedge clk);
      check_eq("no_extra_beat", 32'(valid_out), 32'd0);
    end
  endtask

  initial begin
    int exp_start[4] = '{4, 8, 17, 26};
    int p1_left;

    // Idle scan: pointer walks every port once per cycle.
    clear_traffic();
    for (int i = 0; i < REQ_NUM; i++) qv[i] = 4;
    apply_reset();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check_eq("idle_grant_idx", 32'(grant_idx), 32'(k % 4));
      check_eq("idle_valid_out", 32'(valid_out), 32'd0);
      check_eq("idle_ready_in", 32'(ready_in), 32'd0);
      check_eq("idle_busy", 32'(busy), 32'd0);
    end

    // Single port in debt: two packets, rescan, then further packets as credit returns.
    clear_traffic();
    qv = '{1, 1, 4, 1};
    for (int n = 0; n < 4; n++) add_pkt(2, 3);
    apply_reset();
    run_traffic(400, 0, 0, -1, -1);
    for (int i = 0; i < 4; i++)
      check_eq("pkt_start_cycle", (start_cyc.size() > i) ? 32'(start_cyc[i]) : 32'hffff_ffff, 32'(exp_start[i]));

    // Long-run share between quanta 8 and 2 with random stalls and bubbles.
    clear_traffic();
    qv = '{8, 2, 1, 1};
    for (int n = 0; n < 200; n++) add_pkt(0, 4);
    for (int n = 0; n < 50; n++) add_pkt(1, 4);
    apply_reset();
    run_traffic(6000, 20, 20, -1, -1);
    check_eq("ratio_port0_beats", 32'(beats_sent[0]), 32'd800);
    check_eq("ratio_port1_beats", 32'(beats_sent[1]), 32'd200);

    // Five-cycle downstream stall on the second beat; order depends on the deficit surviving the stall.
    clear_traffic();
    qv = '{5, 4, 1, 1};
    for (int n = 0; n < 3; n++) begin
      add_pkt(0, 4);
      add_pkt(1, 4);
    end
    apply_reset();
    run_traffic(1000, 0, 0, 1, -1);

    // Zero quantum starves only that port.
    clear_traffic();
    qv = '{3, 0, 5, 2};
    for (int p = 0; p < REQ_NUM; p++)
      for (int n = 0; n < 6; n++) add_pkt(p, int'($urandom_range(5, 1)));
    p1_left = drv_q[1].size();
    apply_reset();
    run_traffic(4000, 15, 15, -1, -1);
    check_eq("q0_port1_beats", 32'(beats_sent[1]), 32'd0);
    check_eq("q0_port1_untouched", 32'(drv_q[1].size()), 32'(p1_left));
    for (int p = 0; p < REQ_NUM; p++)
      if (p != 1) check_eq("q0_drained", 32'(drv_q[p].size()), 32'd0);

    // Fully random traffic.
    for (int it = 0; it < 3; it++) begin
      clear_traffic();
      for (int p = 0; p < REQ_NUM; p++) begin
        qv[p] = int'($urandom_range(9, 1));
        for (int n = 0; n < int'($urandom_range(8, 0)); n++) add_pkt(p, int'($urandom_range(6, 1)));
      end
      apply_reset();
      run_traffic(5000, int'($urandom_range(30, 0)), int'($urandom_range(30, 0)), -1, -1);
      for (int p = 0; p < REQ_NUM; p++) check_eq("rand_drained", 32'(drv_q[p].size()), 32'd0);
    end

    // Asynchronous reset in the middle of a packet, then fresh traffic from clean deficits.
    clear_traffic();
    qv = '{8, 1, 1, 1};
    add_pkt(0, 4);
    apply_reset();
    run_traffic(200, 0, 0, -1, 2);
    #2;
    check_eq("pre_rst_busy", 32'(busy), 32'd1);
    check_eq("pre_rst_valid_out", 32'(valid_out), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_valid_out", 32'(valid_out), 32'd0);
    check_eq("async_rst_ready_in", 32'(ready_in), 32'd0);
    check_eq("async_rst_busy", 32'(busy), 32'd0);
    check_eq("async_rst_grant_idx", 32'(grant_idx), 32'd0);
    clear_traffic();
    qv = '{1, 4, 1, 1};
    for (int n = 0; n < 2; n++) begin
      add_pkt(0, 3);
      add_pkt(1, 3);
    end
    apply_reset();
    run_traffic(1000, 10, 10, -1, -1);

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
